// File: rtl/rv_lsu.sv
// Load/store unit: turns a MEM-stage access into a request/grant/rvalid bus transaction and stalls the pipeline until it finishes.
// Optional bus watchdog is built when RV_LSU_TIMEOUT_EN is defined.
module rv_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        stall_o,
  output logic [63:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [7:0]  bus_be_o,
  output logic [63:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [63:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [2:0]  a_q;
  logic        req;
  logic        bad;
  logic        start;
  logic        expire;
  logic [2:0]  a;
  logic [7:0]  be_n;
  logic [63:0] mask;
  logic [63:0] wd_n;
  logic [63:0] shifted;
  logic [63:0] ext;

  assign req = mem_read_i | mem_write_i;
  assign a   = addr_i[2:0];

  always_comb begin
    bad = 1'b0;
    case (funct3_i[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = |a[1:0];
      default: bad = |a;
    endcase
    if (funct3_i == 3'b111) bad = 1'b1;
  end

  assign start      = (state == IDLE) && req && !bad;
  assign misalign_o = (state == IDLE) && req && bad;
  assign stall_o    = start || (state == REQ) || (state == WAIT_R);
  assign bus_req_o  = (state == REQ);

  // Store data is masked to the access size so bytes outside the enables are zero.
  always_comb begin
    be_n = 8'h00;
    mask = 64'h0;
    case (funct3_i[1:0])
      2'b00:   begin be_n = 8'h01 << a; mask = 64'h0000_0000_0000_00FF; end
      2'b01:   begin be_n = 8'h03 << a; mask = 64'h0000_0000_0000_FFFF; end
      2'b10:   begin be_n = 8'h0F << a; mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin be_n = 8'hFF;      mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    wd_n = (wdata_i & mask) << {a, 3'b000};
  end

  always_comb begin
    shifted = bus_rdata_i >> {a_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {56'b0, shifted[7:0]};
      3'b101:  ext = {48'b0, shifted[15:0]};
      3'b110:  ext = {32'b0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

`ifdef RV_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Cleared on entry to REQ and to WAIT_R, so each wait phase gets its own budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == IDLE) || ((state == REQ) && bus_gnt_i)) begin
      cnt <= '0;
    end else if ((state == REQ) || (state == WAIT_R)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (((state == REQ) && !bus_gnt_i) || ((state == WAIT_R) && !bus_rvalid_i))
                  && (cnt == TO_LAST);
  assign err_o  = expire;
`else
  // TIMEOUT has no effect without the watchdog.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      f3_q          <= 3'b000;
      a_q           <= 3'b000;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 64'h0;
      bus_be_o      <= 8'h00;
      bus_wdata_o   <= 64'h0;
      rdata_o       <= 64'h0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q        <= funct3_i;
            a_q         <= a;
            bus_we_o    <= mem_write_i;
            bus_addr_o  <= {addr_i[63:3], 3'b000};
            bus_be_o    <= be_n;
            bus_wdata_o <= wd_n;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            state <= bus_we_o ? DONE : WAIT_R;
          end else if (expire) begin
            state <= DONE;
          end
        end
        WAIT_R: begin
          if (bus_rvalid_i) begin
            rdata_o       <= ext;
            rdata_valid_o <= 1'b1;
            state         <= DONE;
          end else if (expire) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: a vector table of zero-wait accesses plus hand sequences for
// misalignment, bus wait states, reset mid-access and (with RV_LSU_TIMEOUT_EN) the watchdog.
module tb_rv_lsu;

  logic        clk;
  logic        rst;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic        stall_o;
  logic [63:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [7:0]  bus_be_o;
  logic [63:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  rv_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    bit          st;
    bit          both;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    logic [7:0]  be;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
  endtask

  // Drives one access; the bus slave grants after gnt_wait request cycles and returns
  // read data rv_wait cycles after the grant.
  task automatic access(input bit st, input bit both, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int gnt_wait, input int rv_wait, input int exp_stall,
                        input logic [7:0] exp_be, input logic [63:0] exp_wd,
                        input logic [63:0] exp_rd, input string tag);
    int stall_cnt = 0;
    int req_cnt = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int mis_cnt = 0;
    int since_gnt = 0;
    bit done = 1'b0;
    logic [63:0] got_rd = 64'h0;
    mem_read_i  = !st || both;
    mem_write_i = st;
    funct3_i    = f3;
    addr_i      = addr;
    wdata_i     = wd;
    bus_rdata_i = rd;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus_gnt_i    = bus_req_o && (req_cnt == gnt_wait);
      bus_rvalid_i = !st && (since_gnt == rv_wait);
      @(negedge clk);
      if (bus_req_o && req_cnt == 0) begin
        check({tag, " bus_addr"}, bus_addr_o, {addr[63:3], 3'b000});
        check({tag, " bus_be"}, 64'(bus_be_o), 64'(exp_be));
        check({tag, " bus_we"}, 64'(bus_we_o), 64'(st));
        if (st) check({tag, " bus_wdata"}, bus_wdata_o, exp_wd);
      end
      if (stall_o) stall_cnt++;
      else done = 1'b1;
      if (bus_req_o) req_cnt++;
      if (err_o) err_cnt++;
      if (misalign_o) mis_cnt++;
      if (rdata_valid_o) begin
        valid_cnt++;
        got_rd = rdata_o;
      end
      if (bus_gnt_i) since_gnt = 1;
      else if (since_gnt > 0) since_gnt++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check({tag, " completed"}, 64'(done), 64'd1);
    check({tag, " stall cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, " req cycles"}, 64'(req_cnt), 64'(gnt_wait + 1));
    check({tag, " rdata_valid pulses"}, 64'(valid_cnt), st ? 64'd0 : 64'd1);
    check({tag, " err/misalign pulses"}, 64'(err_cnt + mis_cnt), 64'd0);
    if (!st) check({tag, " rdata"}, got_rd, exp_rd);
  endtask

  task automatic misalign_case(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                               input string tag);
    mem_read_i  = !st;
    mem_write_i = st;
    funct3_i    = f3;
    addr_i      = addr;
    wdata_i     = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check({tag, " misalign"}, 64'(misalign_o), 64'd1);
    check({tag, " stall"}, 64'(stall_o), 64'd0);
    check({tag, " bus_req"}, 64'(bus_req_o), 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check({tag, " misalign pulse end"}, 64'(misalign_o), 64'd0);
    check({tag, " no bus access"}, 64'(bus_req_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] last_rd;
    int stall_cnt;
    int valid_cnt;
    int err_cnt;
    int err_at;
    bit done;

    vecs[0]  = '{0, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1, 0, 3'b001, 64'h2006, 64'h1234, 64'h0, 8'hC0, 64'h1234_0000_0000_0000, 64'h0};
    vecs[2]  = '{0, 0, 3'b110, 64'h3004, 64'h0, 64'hFFFF_FFFF_0000_0000, 8'hF0, 64'h0, 64'h0000_0000_FFFF_FFFF};
    vecs[3]  = '{0, 0, 3'b001, 64'h0102, 64'h0, 64'h0000_0000_8001_0000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[4]  = '{0, 0, 3'b101, 64'h0102, 64'h0, 64'h0000_0000_8001_0000, 8'h0C, 64'h0, 64'h0000_0000_0000_8001};
    vecs[5]  = '{0, 0, 3'b010, 64'h0104, 64'h0, 64'h8765_4321_0000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321};
    vecs[6]  = '{0, 0, 3'b100, 64'h0107, 64'h0, 64'hAB00_0000_0000_0000, 8'h80, 64'h0, 64'h0000_0000_0000_00AB};
    vecs[7]  = '{0, 0, 3'b000, 64'h0020, 64'h0, 64'h0000_0000_0000_007F, 8'h01, 64'h0, 64'h0000_0000_0000_007F};
    vecs[8]  = '{0, 0, 3'b011, 64'h0018, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 64'h1122_3344_5566_7788};
    vecs[9]  = '{1, 0, 3'b000, 64'h0005, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 8'h20, 64'h0000_5A00_0000_0000, 64'h0};
    vecs[10] = '{1, 0, 3'b010, 64'h000C, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0};
    vecs[11] = '{1, 0, 3'b011, 64'h0010, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[12] = '{1, 1, 3'b000, 64'h0001, 64'h77, 64'h0, 8'h02, 64'h0000_0000_0000_7700, 64'h0};

    rst = 1'b1;
    idle_inputs();
    funct3_i    = 3'b000;
    addr_i      = 64'h0;
    wdata_i     = 64'h0;
    bus_rdata_i = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset bus_req", 64'(bus_req_o), 64'd0);
    check("reset rdata", rdata_o, 64'h0);
    check("reset bus_be/we", {55'd0, bus_we_o, bus_be_o}, 64'h0);
    check("reset bus_addr", bus_addr_o, 64'h0);
    check("reset flags", {60'd0, rdata_valid_o, misalign_o, err_o, bus_wdata_o != 64'h0}, 64'h0);
    @(posedge clk);
    #1;

    last_rd = 64'h0;
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].st, vecs[i].both, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd,
             0, 1, vecs[i].st ? 2 : 3, vecs[i].be, vecs[i].exp_wd, vecs[i].exp_rd,
             $sformatf("vec%0d", i));
      if (!vecs[i].st) last_rd = vecs[i].exp_rd;
    end
    check("rdata held across stores", rdata_o, last_rd);

    misalign_case(0, 3'b010, 64'h3002, "LW 0x3002");
    misalign_case(0, 3'b001, 64'h1001, "LH 0x1001");
    misalign_case(0, 3'b011, 64'h0004, "LD 0x0004");
    misalign_case(1, 3'b001, 64'h0003, "SH 0x0003");
    misalign_case(0, 3'b111, 64'h0000, "funct3 111");

`ifdef RV_LSU_TIMEOUT_EN
    access(0, 0, 3'b011, 64'h40, 64'h0, 64'hFEDC_BA98_7654_3210, 2, 3, 7,
           8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210, "LD wait");
`else
    access(0, 0, 3'b011, 64'h40, 64'h0, 64'hFEDC_BA98_7654_3210, 5, 3, 10,
           8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210, "LD wait");
`endif

    // Reset while waiting for read data; the late rvalid must be ignored.
    mem_read_i  = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 64'h80;
    bus_rdata_i = 64'h0000_0000_5555_AAAA;
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt_i  = 1'b0;
    mem_read_i = 1'b0;
    @(negedge clk);
    check("pre-reset in WAIT_R stall", 64'(stall_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus_rvalid_i = 1'b1;
    @(negedge clk);
    check("post-reset stall", 64'(stall_o), 64'd0);
    check("post-reset rdata", rdata_o, 64'h0);
    check("post-reset bus outputs", {54'd0, bus_req_o, bus_we_o, bus_be_o}, 64'h0);
    check("post-reset bus_addr", bus_addr_o, 64'h0);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("late rvalid ignored valid", 64'(rdata_valid_o), 64'd0);
    check("late rvalid ignored rdata", rdata_o, 64'h0);
    @(posedge clk);
    #1;
    access(0, 0, 3'b100, 64'h0, 64'h0, 64'h0000_0000_0000_00FE, 0, 1, 3,
           8'h01, 64'h0, 64'h0000_0000_0000_00FE, "LBU after reset");

`ifdef RV_LSU_TIMEOUT_EN
    mem_read_i  = 1'b1;
    funct3_i    = 3'b000;
    addr_i      = 64'h100;
    stall_cnt   = 0;
    valid_cnt   = 0;
    err_cnt     = 0;
    err_at      = -1;
    done        = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (err_o) begin
        err_cnt++;
        err_at = cyc;
      end
      if (stall_o) stall_cnt++;
      else done = 1'b1;
      if (rdata_valid_o) valid_cnt++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("timeout completed", 64'(done), 64'd1);
    check("timeout err pulses", 64'(err_cnt), 64'd1);
    check("timeout err cycle", 64'(err_at), 64'd4);
    check("timeout stall cycles", 64'(stall_cnt), 64'd5);
    check("timeout rdata_valid", 64'(valid_cnt), 64'd0);
    check("timeout rdata unchanged", rdata_o, 64'h0000_0000_0000_00FE);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit between the MEM-stage pipeline register and a valid/grant data bus.
- Replaces the single-cycle data memory port with a multi-cycle handshake.
- Generates byte enables, write-data lane alignment, load extraction and sign/zero extension.
- Holds the pipeline via stall_o until each access completes.

Parameters:
- TIMEOUT, 255, max cycles waited for bus_gnt_i or bus_rvalid_i (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mem_read_i  in  1  load request, held stable while stall_o=1
- mem_write_i  in  1  store request, held stable while stall_o=1
- funct3_i  in  3  access size and sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
- addr_i  in  64  byte address (ALU result)
- wdata_i  in  64  store data (forwarded rs2), LSB-justified
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- rdata_o  out  64  extended load result
- rdata_valid_o  out  1  one-cycle pulse, rdata_o valid
- misalign_o  out  1  one-cycle pulse: misaligned address or funct3=111
- err_o  out  1  one-cycle timeout pulse
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  64  {addr[63:3],3'b000}
- bus_be_o  out  8  byte enables
- bus_wdata_o  out  64  lane-shifted store data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  64  read data, full doubleword

Behaviour:
- Reset: synchronous active-high on clk. State IDLE; all outputs 0; timeout counter 0. Reset mid-transaction abandons it; any later bus_rvalid_i in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE, request present (mem_read_i|mem_write_i):
  - Both set → treated as store.
  - Misaligned (H: addr[0]!=0; W/WU: addr[1:0]!=0; D: addr[2:0]!=0) or funct3=111:
    - misalign_o=1 for the cycle; no bus access; stall_o=0; stay IDLE.
  - Otherwise:
    - stall_o=1 combinationally this cycle.
    - Latch addr, funct3, direction, be, shifted wdata.
    - Go to REQ.
- REQ:
  - bus_req_o=1 and bus outputs stable from latched values; stall_o=1.
  - bus_gnt_i=1 → store goes to DONE, load goes to WAIT_R.
  - Grant is sampled the same cycle as the request; zero-wait grant allowed.
- WAIT_R:
  - bus_req_o=0; stall_o=1.
  - bus_rvalid_i=1 → capture extended data into rdata_o; go to DONE.
- DONE:
  - stall_o=0; rdata_valid_o=1 for loads (0 for stores); pipeline advances on this edge.
  - Inputs still carry the old request and are ignored; next state IDLE.
- Minimum access latency: 2 stall cycles for a store, 3 for a load (zero-wait bus).
- Byte enables: B 8'h01<<a, H 8'h03<<a, W 8'h0F<<a, D 8'hFF, where a=addr[2:0].
- Store data: bus_wdata_o = wdata_i << (8*a). Bytes outside the enables are don't-care; the bench requires them to be 0.
- Load extraction: s = bus_rdata_i >> (8*a), then:
  - B sign-extends s[7:0]; H sign-extends s[15:0]; W sign-extends s[31:0]; D passes s.
  - BU/HU/WU zero-extend.
- rdata_o holds its value until the next load completes.

Optional Feature:
- Macro: RV_LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ or WAIT_R and increments every cycle spent in REQ/WAIT_R.
  - When it reaches TIMEOUT with no gnt/rvalid: err_o=1 for one cycle; bus_req_o drops; go to DONE with rdata_valid_o=0 and rdata_o unchanged.
- Undefined: no counter; err_o tied 0; the unit waits indefinitely.

Test Plan:
- LB, addr=0x1003, bus_rdata=0x0000_0000_8000_0000, gnt and rvalid each one cycle after request → rdata_o=0xFFFF_FFFF_FFFF_FF80, rdata_valid_o pulse, stall_o high exactly 3 cycles.
- SH, addr=0x2006, wdata=0x1234 → bus_be_o=8'hC0, bus_wdata_o=0x1234_0000_0000_0000, bus_addr_o=0x2000, bus_we_o=1; stall ends the cycle after gnt.
- LW, addr=0x3002 → misalign_o pulse, bus_req_o stays 0, stall_o 0. LWU, addr=0x3004, rdata=0xFFFF_FFFF_0000_0000 → rdata_o=0x0000_0000_FFFF_FFFF.
- LD, addr=0x40: hold gnt low 5 cycles, then rvalid 3 cycles after gnt → bus_req_o high through the gnt cycle, stall_o continuous, rdata_o equals bus_rdata_i exactly.
- Reset asserted in WAIT_R, rvalid arriving the cycle after → all outputs 0, no rdata_valid_o pulse, next LBU, addr=0x0 completes normally.
- With RV_LSU_TIMEOUT_EN and TIMEOUT=4, gnt never asserted → err_o pulse at the 4th REQ cycle, stall released the following cycle, rdata_valid_o=0.
